// File: rtl/serdes_pkg.sv
// serdes_pkg: shared definitions for the SerDes bus scheduler.
//   state_e         scheduler FSM state encoding
//   DIR_WR / DIR_RD bus direction constants (match SerDes_Sel polarity)
//   *_DEF           default parameter values for serdes_sched
//   max3()          helper for sizing the shared cycle counter
package serdes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_e;

    localparam logic DIR_WR = 1'b1;
    localparam logic DIR_RD = 1'b0;

    localparam int WIDTH_DEF      = 4;
    localparam int TURN_CYC_DEF   = 2;
    localparam int RD_TIMEOUT_DEF = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/serdes_rr_arb.sv
// serdes_rr_arb: two-requester round-robin arbiter (write vs read).
//   mem_clk, rst_n  clock / async active-low reset
//   req_wr, req_rd  pending requests
//   adv             a grant is being taken this cycle; move the pointer
//   gnt_wr, gnt_rd  combinational one-hot grant (at most one high)
// The pointer holds the preferred direction for the next contention; it
// resets to write and flips to the opposite of whatever was granted.
module serdes_rr_arb
    import serdes_pkg::*;
(
    input  logic mem_clk,
    input  logic rst_n,
    input  logic req_wr,
    input  logic req_rd,
    input  logic adv,
    output logic gnt_wr,
    output logic gnt_rd
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_wr = req_wr & ((ptr_q == DIR_WR) | ~req_rd);
        gnt_rd = req_rd & ~gnt_wr;
        ptr_d  = ptr_q;
        if (adv & gnt_wr)      ptr_d = DIR_RD;
        else if (adv & gnt_rd) ptr_d = DIR_WR;
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= DIR_WR;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/serdes_sched.sv
// serdes_sched: schedules write bursts and read captures on a shared,
// half-duplex SerDes, inserting bus turnaround idle time on direction change.
//   mem_clk, rst_n                  clock / async active-low reset
//   wr_req, wr_data, wr_ack, wr_done   write requester handshake
//   rd_req, rd_ack, rd_valid, rd_data, rd_err  read requester handshake
//   serdes_en, serdes_sel, serdes_wdata   controls to the SerDes
//   serdes_rdata, serdes_status           returns from the SerDes
//   busy                            high whenever the FSM is not idle
// All outputs are registered.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | bus quiet, waiting for a request to grant
// TURN    | direction change: serdes_en low for TURN_CYC cycles
// WR      | serialising serdes_wdata for WIDTH cycles
// RD      | deserialising, waiting for serdes_status (bounded by timeout)
module serdes_sched
    import serdes_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int TURN_CYC   = TURN_CYC_DEF,
    parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
    input  logic             mem_clk,
    input  logic             rst_n,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    output logic             wr_done,
    input  logic             rd_req,
    output logic             rd_ack,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_err,
    output logic             serdes_en,
    output logic             serdes_sel,
    output logic [WIDTH-1:0] serdes_wdata,
    input  logic [WIDTH-1:0] serdes_rdata,
    input  logic             serdes_status,
    output logic             busy
);

    localparam int CNT_MAX = max3(WIDTH, TURN_CYC, RD_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam bit HAS_TURN = (TURN_CYC > 0);

    // Down-counter reload values; the state exits when the counter hits 0.
    localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] RD_LD   = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgt_dir_q, tgt_dir_d;
    logic             last_dir_q, last_dir_d;
    logic             wr_ack_q, wr_ack_d;
    logic             wr_done_q, wr_done_d;
    logic             rd_ack_q, rd_ack_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_err_q, rd_err_d;
    logic             serdes_en_q, serdes_en_d;
    logic             serdes_sel_q, serdes_sel_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] serdes_wdata_q, serdes_wdata_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic gnt_wr, gnt_rd, arb_adv, grant_dir;

    serdes_rr_arb u_arb (
        .mem_clk (mem_clk),
        .rst_n   (rst_n),
        .req_wr  (wr_req),
        .req_rd  (rd_req),
        .adv     (arb_adv),
        .gnt_wr  (gnt_wr),
        .gnt_rd  (gnt_rd)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tgt_dir_d      = tgt_dir_q;
        last_dir_d     = last_dir_q;
        wr_ack_d       = 1'b0;
        wr_done_d      = 1'b0;
        rd_ack_d       = 1'b0;
        rd_valid_d     = 1'b0;
        rd_err_d       = 1'b0;
        serdes_en_d    = serdes_en_q;
        serdes_sel_d   = serdes_sel_q;
        serdes_wdata_d = serdes_wdata_q;
        rd_data_d      = rd_data_q;
        arb_adv        = 1'b0;
        grant_dir      = gnt_wr ? DIR_WR : DIR_RD;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_wr | gnt_rd) begin
                    arb_adv   = 1'b1;
                    tgt_dir_d = grant_dir;
                    // serdes_en is low here, so moving sel now is safe.
                    serdes_sel_d = grant_dir;
                    if (gnt_wr) begin
                        wr_ack_d       = 1'b1;
                        serdes_wdata_d = wr_data;
                    end else begin
                        rd_ack_d = 1'b1;
                    end
                    if (HAS_TURN && (grant_dir != last_dir_q)) begin
                        state_d = ST_TURN;
                        cnt_d   = TURN_LD;
                    end else begin
                        state_d     = (grant_dir == DIR_WR) ? ST_WR : ST_RD;
                        cnt_d       = (grant_dir == DIR_WR) ? WR_LD : RD_LD;
                        serdes_en_d = 1'b1;
                    end
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d     = (tgt_dir_q == DIR_WR) ? ST_WR : ST_RD;
                    cnt_d       = (tgt_dir_q == DIR_WR) ? WR_LD : RD_LD;
                    serdes_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR: begin
                if (cnt_q == '0) begin
                    state_d     = ST_IDLE;
                    serdes_en_d = 1'b0;
                    wr_done_d   = 1'b1;
                    last_dir_d  = DIR_WR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RD: begin
                // A word completing on the final allowed cycle still wins.
                if (serdes_status) begin
                    state_d     = ST_IDLE;
                    serdes_en_d = 1'b0;
                    rd_data_d   = serdes_rdata;
                    rd_valid_d  = 1'b1;
                    last_dir_d  = DIR_RD;
                end else if (cnt_q == '0) begin
                    state_d     = ST_IDLE;
                    serdes_en_d = 1'b0;
                    rd_err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                serdes_en_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            tgt_dir_q      <= DIR_WR;
            last_dir_q     <= DIR_WR;
            wr_ack_q       <= 1'b0;
            wr_done_q      <= 1'b0;
            rd_ack_q       <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_err_q       <= 1'b0;
            serdes_en_q    <= 1'b0;
            serdes_sel_q   <= 1'b0;
            busy_q         <= 1'b0;
            serdes_wdata_q <= '0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tgt_dir_q      <= tgt_dir_d;
            last_dir_q     <= last_dir_d;
            wr_ack_q       <= wr_ack_d;
            wr_done_q      <= wr_done_d;
            rd_ack_q       <= rd_ack_d;
            rd_valid_q     <= rd_valid_d;
            rd_err_q       <= rd_err_d;
            serdes_en_q    <= serdes_en_d;
            serdes_sel_q   <= serdes_sel_d;
            busy_q         <= busy_d;
            serdes_wdata_q <= serdes_wdata_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign wr_ack       = wr_ack_q;
    assign wr_done      = wr_done_q;
    assign rd_ack       = rd_ack_q;
    assign rd_valid     = rd_valid_q;
    assign rd_err       = rd_err_q;
    assign rd_data      = rd_data_q;
    assign serdes_en    = serdes_en_q;
    assign serdes_sel   = serdes_sel_q;
    assign serdes_wdata = serdes_wdata_q;
    assign busy         = busy_q;

endmodule
